// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall / control-transfer flush controller with RUN/STEP/HALTED debug FSM; PIPE_CTRL_STEP_EN enables single-step.
// Control outputs are same-cycle combinational; state and saturating counters register on the next clk edge; stalls hold PC and IF/ID.
module pipe_hazard_ctrl #(
    parameter int W = 5,
    parameter int B = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] id_rs,
    input  logic [W-1:0] id_rt,
    input  logic         id_uses_rt,
    input  logic         ex_MemRead,
    input  logic [W-1:0] ex_rt,
    input  logic         mem_take,
    input  logic         halt_in,
    input  logic         step_req,
    input  logic         run_req,
    output logic         pc_write,
    output logic         ifid_write,
    output logic         ifid_flush,
    output logic         idex_flush,
    output logic         exmem_flush,
    output logic [1:0]   state,
    output logic [B-1:0] stall_cnt,
    output logic [B-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STEP   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]   state_q;
    logic [1:0]   state_d;
    logic [B-1:0] stall_q;
    logic [B-1:0] flush_q;
    logic         hz;
    logic         active;
    logic         step_go;
    logic         stall_evt;
    logic         flush_evt;

`ifdef PIPE_CTRL_STEP_EN
    assign step_go = step_req;
`else
    // Port kept for pin compatibility; STEP is unreachable in this build.
    assign step_go = step_req & 1'b0;
`endif

    assign hz = ex_MemRead && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Encoding 3 is never entered but behaves as HALTED if it ever appears.
    assign active    = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign flush_evt = active && mem_take;
    assign stall_evt = active && hz && !mem_take;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (!active) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else if (mem_take) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (hz) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (halt_in) state_d = ST_HALTED;
            ST_STEP: state_d = ST_HALTED;
            default: begin
                if (run_req)      state_d = ST_RUN;
                else if (step_go) state_d = ST_STEP;
                else              state_d = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_evt && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            if (flush_evt && (flush_q != '1))
                flush_q <= flush_q + 1'b1;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. Generates PC/IF-ID write enables and flush (bubble) requests for the IF/ID, ID/EX and EX/MEM pipe registers from load-use hazards and MEM-stage control transfers. Runs a RUN/STEP/HALTED FSM for program halt and single-step debug. Keeps saturating stall and flush event counters. Sits beside the pipe registers and drives their enable and flush inputs.

## Interface
- W, 5, register address width
- B, 32, event counter width
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- id_rs  in  W  rs field of the instruction in ID (IF/ID bits 25:21)
- id_rt  in  W  rt field of the instruction in ID (IF/ID bits 20:16)
- id_uses_rt  in  1  instruction in ID reads rt as a source
- ex_MemRead  in  1  MemRead control bit held in ID/EX
- ex_rt  in  W  inst_20_16 field held in ID/EX
- mem_take  in  1  branch taken or jump resolved in MEM this cycle
- halt_in  in  1  HALT instruction retiring in WB this cycle
- step_req  in  1  debug single-step request (level, sampled per cycle)
- run_req  in  1  debug resume request
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_flush  out  1  zero all control fields loaded into ID/EX
- exmem_flush  out  1  zero all control fields loaded into EX/MEM
- state  out  2  FSM state: RUN=0, STEP=1, HALTED=2 (3 unused; decodes as HALTED)
- stall_cnt  out  B  load-use stall cycles
- flush_cnt  out  B  control-transfer flush events

## Operation
- Hazard term: hz = ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- Active = state is RUN or STEP. Control outputs are combinational (Mealy) from state and inputs.
- Active and mem_take: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1. hz is ignored.
- Active and hz and !mem_take: pc_write=0, ifid_write=0, idex_flush=1, other flushes 0.
- Active otherwise: pc_write=1, ifid_write=1, all flushes 0.
- HALTED: pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0, exmem_flush=0. Bubbles drain the later stages.
- Transitions:
  - RUN -> HALTED on halt_in.
  - HALTED -> RUN on run_req.
  - HALTED -> STEP on step_req & !run_req.
  - STEP -> HALTED unconditionally after one cycle; halt_in in STEP also gives HALTED.
  - All other cases hold state.
- Priority: reset > run_req > step_req in HALTED. halt_in wins over any step/run request in RUN/STEP.
- stall_cnt increments in cycles where active & hz & !mem_take.
- flush_cnt increments in cycles where active & mem_take.
- Both counters saturate at 2^B-1 (no wrap) and hold while HALTED.

## Timing
- Control outputs: zero latency, same-cycle response to inputs.
- state and counters are registered and update on the rising clk edge following the qualifying cycle.
- A load-use stall lasts exactly one cycle. The load moves to MEM next cycle, which clears hz.
- Reset (sync): state=RUN, stall_cnt=0, flush_cnt=0.
- While reset is high, regardless of other inputs: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, exmem_flush=1.
- Reset asserted mid-stall or mid-STEP: takes effect at the next edge; no residual step or stall.
- halt_in and mem_take in the same RUN cycle: flush outputs per mem_take this cycle, flush_cnt increments, then HALTED.

## Configuration
- PIPE_CTRL_STEP_EN defined: STEP state and step_req behaviour included as above.
- PIPE_CTRL_STEP_EN undefined: step_req ignored and STEP unreachable. HALTED is exited only by run_req; the port is kept.

## Test plan
- Load-use: ex_MemRead=1, ex_rt=8, id_rs=8 -> exactly one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cnt 0->1.
- rt dependence off/on: ex_rt=0 with id_rs=0 -> no stall. ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall; with id_uses_rt=1 -> stall.
- Hazard plus mem_take in the same cycle -> all three flushes=1, pc_write=1; flush_cnt +1, stall_cnt unchanged.
- halt_in pulse -> state=2 next cycle, idex_flush=1. step_req for 3 cycles (macro on) -> STEP cycles alternate with HALTED (1,2,1). run_req -> state=0.
- Saturation: preload with B=4, 16 consecutive hazard cycles -> stall_cnt stops at 15.
- Reset asserted while state=1 -> next cycle state=0 and counters 0; during reset all flushes=1 and pc_write=0.
